// File: rtl/fir_hpf_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : fir_hpf_pkg
// Brief  : Shared sizes, high-pass coefficients and stimulus table for fir_hpf.
// Rev    : 1.0
// ============================================================================
package fir_hpf_pkg;

    localparam int NTAPS = 51;
    localparam int DW    = 16;
    localparam int CW    = 16;
    localparam int ACCW  = 40;

    localparam int c_IDX_W = 9;
    localparam logic [c_IDX_W-1:0] c_DC_START  = 9'd64;
    localparam logic [c_IDX_W-1:0] c_NYQ_START = 9'd192;
    localparam logic [c_IDX_W-1:0] c_SEQ_LEN   = 9'd320;

    localparam logic signed [DW-1:0] c_AMP_IMP  = 16'sd16384;
    localparam logic signed [DW-1:0] c_AMP_STEP = 16'sd8192;

    typedef enum logic [1:0] {
        SEG_IMPULSE = 2'd0,
        SEG_ZERO    = 2'd1,
        SEG_DC      = 2'd2,
        SEG_NYQ     = 2'd3
    } seg_e;

    // Hamming-windowed sinc HPF, fc = 0.25*fs, Q1.15. Centre tap trimmed
    // from 16384 to 16416 so the taps sum to exactly zero (no DC leakage).
    localparam logic signed [CW-1:0] COEF [NTAPS] = '{
        -16'sd33,    16'sd0,   16'sd43,    16'sd0,   -16'sd68,    16'sd0,
         16'sd112,   16'sd0,  -16'sd180,   16'sd0,    16'sd277,   16'sd0,
        -16'sd410,   16'sd0,   16'sd594,   16'sd0,   -16'sd853,   16'sd0,
         16'sd1242,  16'sd0,  -16'sd1903,  16'sd0,    16'sd3364,  16'sd0,
        -16'sd10393, 16'sd16416, -16'sd10393,
         16'sd0,   16'sd3364,  16'sd0,  -16'sd1903,  16'sd0,   16'sd1242,
         16'sd0,  -16'sd853,   16'sd0,   16'sd594,   16'sd0,  -16'sd410,
         16'sd0,   16'sd277,   16'sd0,  -16'sd180,   16'sd0,   16'sd112,
         16'sd0,  -16'sd68,    16'sd0,   16'sd43,    16'sd0,  -16'sd33
    };

    function automatic seg_e stim_seg(input logic [c_IDX_W-1:0] idx);
        if (idx == '0)               return SEG_IMPULSE;
        else if (idx < c_DC_START)   return SEG_ZERO;
        else if (idx < c_NYQ_START)  return SEG_DC;
        else                         return SEG_NYQ;
    endfunction

    function automatic logic signed [DW-1:0] stim(input logic [c_IDX_W-1:0] idx);
        case (stim_seg(idx))
            SEG_IMPULSE: return c_AMP_IMP;
            SEG_DC:      return c_AMP_STEP;
            SEG_NYQ:     return idx[0] ? -c_AMP_STEP : c_AMP_STEP;
            default:     return '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_hpf_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : fir_hpf_core
// Brief  : 51-tap direct-form FIR, full-precision MACs, saturated Q15 output.
// Rev    : 1.0
// ============================================================================
module fir_hpf_core #(
    parameter int NTAPS = fir_hpf_pkg::NTAPS,
    parameter int DW    = fir_hpf_pkg::DW,
    parameter int CW    = fir_hpf_pkg::CW,
    parameter int ACCW  = fir_hpf_pkg::ACCW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] x_in,
    output logic signed [DW-1:0] y_out,
    output logic                 y_valid
);
    import fir_hpf_pkg::*;

    localparam int c_PW   = DW + CW;
    localparam int c_FRAC = CW - 1;
    localparam int c_CNTW = $clog2(NTAPS + 1);
    localparam logic [c_CNTW-1:0] c_CNT_FULL = c_CNTW'(NTAPS);
    localparam logic signed [ACCW-1:0] c_YMAX =
        $signed({{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}});
    localparam logic signed [ACCW-1:0] c_YMIN =
        $signed({{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}});

    logic signed [DW-1:0]   r_dly  [1:NTAPS-1];
    logic signed [DW-1:0]   w_tap  [NTAPS];
    logic signed [c_PW-1:0] w_prod [NTAPS];
    logic signed [ACCW-1:0] w_acc;
    logic signed [ACCW-1:0] w_shift;
    logic signed [DW-1:0]   w_sat;
    logic [c_CNTW-1:0]      r_cnt;

    assign w_tap[0] = x_in;

    generate
        for (genvar k = 1; k < NTAPS; k++) begin : g_tap
            assign w_tap[k] = r_dly[k];
        end
        for (genvar k = 0; k < NTAPS; k++) begin : g_mul
            assign w_prod[k] = c_PW'(w_tap[k]) * c_PW'(COEF[k]);
        end
    endgenerate

    always_comb begin
        w_acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            w_acc = w_acc + ACCW'(w_prod[k]);
        end
    end

    assign w_shift = w_acc >>> c_FRAC;

    always_comb begin
        w_sat = w_shift[DW-1:0];
        if (w_shift > c_YMAX) begin
            w_sat = c_YMAX[DW-1:0];
        end else if (w_shift < c_YMIN) begin
            w_sat = c_YMIN[DW-1:0];
        end
    end

    // r_cnt counts edges since reset; x_in comes out of reset on the same
    // edge, so the line is full once NTAPS samples have been counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < NTAPS; k++) begin
                r_dly[k] <= '0;
            end
            y_out   <= '0;
            y_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_dly[1] <= x_in;
            for (int k = 2; k < NTAPS; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
            y_out <= w_sat;
            if (r_cnt != c_CNT_FULL) begin
                r_cnt <= r_cnt + c_CNTW'(1);
            end
            if (r_cnt == c_CNT_FULL) begin
                y_valid <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_hpf_top.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : fir_hpf_top
// Brief  : Self-running 320-sample stimulus source feeding the HPF core.
// Rev    : 1.0
// ============================================================================
module fir_hpf_top #(
    parameter int NTAPS = fir_hpf_pkg::NTAPS,
    parameter int DW    = fir_hpf_pkg::DW,
    parameter int CW    = fir_hpf_pkg::CW,
    parameter int ACCW  = fir_hpf_pkg::ACCW
) (
    input  logic clk,
    input  logic rst
);
    import fir_hpf_pkg::*;

    logic [c_IDX_W-1:0]   sample_idx;
    logic signed [DW-1:0] sample_x;
    logic signed [DW-1:0] fir_y;
    logic                 fir_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            sample_idx <= '0;
            sample_x   <= '0;
        end else begin
            if (sample_idx == c_SEQ_LEN - c_IDX_W'(1)) begin
                sample_idx <= '0;
            end else begin
                sample_idx <= sample_idx + c_IDX_W'(1);
            end
            sample_x <= stim(sample_idx);
        end
    end

    fir_hpf_core #(
        .NTAPS (NTAPS),
        .DW    (DW),
        .CW    (CW),
        .ACCW  (ACCW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .x_in    (sample_x),
        .y_out   (fir_y),
        .y_valid (fir_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_fir_hpf_top.sv
`timescale 1ns/1ps
// Directed bench for fir_hpf_top: reset, impulse, DC, Nyquist, wrap, mid-run reset.
module tb_fir_hpf_top;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fir_hpf_top dut (
        .clk (clk),
        .rst (rst)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int edge_n = 0;

    int coef_tab [51] = '{
        -33, 0, 43, 0, -68, 0, 112, 0, -180, 0, 277, 0, -410, 0, 594, 0,
        -853, 0, 1242, 0, -1903, 0, 3364, 0, -10393, 16416, -10393,
        0, 3364, 0, -1903, 0, 1242, 0, -853, 0, 594, 0, -410, 0, 277,
        0, -180, 0, 112, 0, -68, 0, 43, 0, -33
    };

    // Impulse of 16384 through each coefficient: floor(COEF/2).
    int imp_tab [51] = '{
        -17, 0, 21, 0, -34, 0, 56, 0, -90, 0, 138, 0, -205, 0, 297, 0,
        -427, 0, 621, 0, -952, 0, 1682, 0, -5197, 8208, -5197,
        0, 1682, 0, -952, 0, 621, 0, -427, 0, 297, 0, -205, 0, 138,
        0, -90, 0, 56, 0, -34, 0, 21, 0, -17
    };

    function automatic int tb_stim(int j);
        int i;
        if (j < 0) return 0;
        i = j % 320;
        if (i == 0)   return 16384;
        if (i < 64)   return 0;
        if (i < 192)  return 8192;
        return (i % 2 == 0) ? 8192 : -8192;
    endfunction

    // fir_y at edge t after release: newest tap holds sample t-2.
    function automatic int ref_y(int t);
        longint acc;
        longint y;
        acc = 0;
        for (int k = 0; k < 51; k++) begin
            acc += longint'(coef_tab[k]) * longint'(tb_stim(t - 2 - k));
        end
        y = acc >>> 15;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic advance_to(int t);
        while (edge_n < t) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (int'(dut.sample_idx) !== 0) begin
            n_err++; $display("FAIL reset_idx: got %0d expected 0", dut.sample_idx);
        end
        n_cmp++;
        if (int'(dut.sample_x) !== 0) begin
            n_err++; $display("FAIL reset_x: got %0d expected 0", dut.sample_x);
        end
        n_cmp++;
        if (int'(dut.fir_y) !== 0) begin
            n_err++; $display("FAIL reset_y: got %0d expected 0", dut.fir_y);
        end
        n_cmp++;
        if (dut.fir_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b expected 0", dut.fir_valid);
        end
    endtask

    task automatic test_impulse(string tag);
        rst    = 1'b0;
        edge_n = 0;
        tick();
        n_cmp++;
        if (int'(dut.sample_x) !== 16384) begin
            n_err++; $display("FAIL %s_first_x: got %0d expected 16384", tag, dut.sample_x);
        end
        n_cmp++;
        if (int'(dut.sample_idx) !== 1) begin
            n_err++; $display("FAIL %s_first_idx: got %0d expected 1", tag, dut.sample_idx);
        end
        for (int j = 0; j < 51; j++) begin
            tick();
            n_cmp++;
            if (int'(dut.fir_y) !== imp_tab[j]) begin
                n_err++;
                $display("FAIL %s_y[%0d]: got %0d expected %0d", tag, j, dut.fir_y, imp_tab[j]);
            end
            n_cmp++;
            if (dut.fir_valid !== (edge_n >= 52)) begin
                n_err++;
                $display("FAIL %s_valid@%0d: got %b expected %b", tag, edge_n, dut.fir_valid, (edge_n >= 52));
            end
        end
    endtask

    task automatic test_dc();
        int d;
        advance_to(116);
        for (int t = 116; t <= 193; t++) begin
            advance_to(t);
            d = int'(dut.fir_y);
            n_cmp++;
            if (d > 2 || d < -2) begin
                n_err++; $display("FAIL dc_y@%0d: got %0d expected |y|<=2", t, d);
            end
        end
    endtask

    task automatic test_nyquist();
        int d;
        int e;
        for (int t = 244; t <= 319; t++) begin
            advance_to(t);
            d = int'(dut.fir_y);
            e = ((t - 2) % 2 == 0) ? -8208 : 8208;
            n_cmp++;
            if (d > e + 1 || d < e - 1) begin
                n_err++; $display("FAIL nyq_y@%0d: got %0d expected %0d+-1", t, d, e);
            end
        end
    endtask

    task automatic test_wrap();
        advance_to(320);
        n_cmp++;
        if (int'(dut.sample_idx) !== 0) begin
            n_err++; $display("FAIL wrap_idx: got %0d expected 0", dut.sample_idx);
        end
        tick();
        n_cmp++;
        if (int'(dut.sample_x) !== 16384) begin
            n_err++; $display("FAIL wrap_x: got %0d expected 16384", dut.sample_x);
        end
        for (int t = 321; t <= 372; t++) begin
            advance_to(t);
            n_cmp++;
            if (int'(dut.fir_y) !== ref_y(t)) begin
                n_err++; $display("FAIL wrap_y@%0d: got %0d expected %0d", t, dut.fir_y, ref_y(t));
            end
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (int'(dut.sample_idx) == 150) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL mid_search: got idx %0d expected 150 within 400 clocks", dut.sample_idx);
        end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (int'(dut.sample_idx) !== 0 || int'(dut.sample_x) !== 0) begin
            n_err++; $display("FAIL mid_clear_src: got idx %0d x %0d expected 0 0", dut.sample_idx, dut.sample_x);
        end
        n_cmp++;
        if (int'(dut.fir_y) !== 0 || dut.fir_valid !== 1'b0) begin
            n_err++; $display("FAIL mid_clear_fir: got y %0d valid %b expected 0 0", dut.fir_y, dut.fir_valid);
        end
        test_impulse("mid");
    endtask

    initial begin
        test_reset();
        test_impulse("imp");
        test_dc();
        test_nyquist();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
